// File: rtl/req_gnt_pkg.sv
// Shared encodings and default sizing for the round-robin req/gnt responder.
package req_gnt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    GRANT = 2'd2
  } state_t;

  localparam int N_REQ_DEF      = 4;
  localparam int ID_W_DEF       = 2;
  localparam int SVC_CYCLES_DEF = 3;
  localparam int CNT_W_DEF      = 4;

endpackage

// File: rtl/req_gnt_responder_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, wrapping modulo N_REQ.
module rr_pick
  import req_gnt_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int ID_W  = ID_W_DEF
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  winner,
  output logic             valid
);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    winner = '0;
    valid  = 1'b0;
    sum    = '0;
    idx    = '0;
    // Scan from the farthest offset down so the offset nearest ptr wins last.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (ID_W + 1)'(i);
      if (sum >= (ID_W + 1)'(N_REQ)) sum = sum - (ID_W + 1)'(N_REQ);
      idx = sum[ID_W-1:0];
      if (req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/req_gnt_responder.sv
// Multi-requester req/gnt responder: round-robin selection, fixed service time,
// one-cycle grant pulse, abort when the selected requester withdraws.
module req_gnt_responder
  import req_gnt_pkg::*;
#(
  parameter int N_REQ      = N_REQ_DEF,
  parameter int ID_W       = ID_W_DEF,
  parameter int SVC_CYCLES = SVC_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             busy,
  output logic             abort
);

  state_t           state, state_nxt;
  logic [ID_W-1:0]  sel, sel_nxt, sel_inc;
  logic [ID_W-1:0]  ptr, ptr_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [N_REQ-1:0] gnt_nxt;
  logic             busy_nxt, abort_nxt;
  logic [ID_W-1:0]  pick_id;
  logic             pick_valid;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (pick_id),
    .valid  (pick_valid)
  );

  assign sel_inc = (sel == ID_W'(N_REQ - 1)) ? '0 : sel + 1'b1;
  assign gnt_id  = sel;

  // NOTE: all registers, including the gnt/abort pulses, take their reset value asynchronously so nothing stale leaks past a mid-service reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sel   <= '0;
      ptr   <= '0;
      cnt   <= '0;
      gnt   <= '0;
      busy  <= 1'b0;
      abort <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state <= state_nxt;
      sel   <= sel_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
      gnt   <= gnt_nxt;
      busy  <= busy_nxt;
      abort <= abort_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_valid) state_nxt = SERVE;
      SERVE: begin
        if (!req[sel])       state_nxt = IDLE;
        else if (cnt == '0)  state_nxt = GRANT;
      end
      GRANT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sel_nxt   = sel;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    gnt_nxt   = '0;
    busy_nxt  = busy;
    abort_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          sel_nxt  = pick_id;
          busy_nxt = 1'b1;
          cnt_nxt  = CNT_W'(SVC_CYCLES - 1);
        end
      end
      SERVE: begin
        if (!req[sel]) begin
          abort_nxt = 1'b1;
          busy_nxt  = 1'b0;
          ptr_nxt   = sel_inc;
        end else if (cnt == '0) begin
          gnt_nxt[sel] = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      GRANT: begin
        busy_nxt = 1'b0;
        ptr_nxt  = sel_inc;
      end
      default: begin
        busy_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_req_gnt_responder.sv
// Scoreboard bench: expected grant/abort cycles are queued when stimulus is driven
// and popped when the responder pulses gnt or abort; a second instance covers SVC_CYCLES=1.
module tb_req_gnt_responder;

  typedef struct {
    int id;
    int cyc;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       abort;

  logic [1:0] req2;
  logic [1:0] gnt2;
  logic [0:0] gnt_id2;
  logic       busy2;
  logic       abort2;

  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  exp_t gq[$];
  int   aq[$];

  logic [1:0] lim_gnt  [6] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00};
  logic       lim_busy [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  req_gnt_responder u_dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .busy   (busy),
    .abort  (abort)
  );

  req_gnt_responder #(
    .N_REQ      (2),
    .ID_W       (1),
    .SVC_CYCLES (1),
    .CNT_W      (1)
  ) u_dut_lim (
    .clk    (clk),
    .rst    (rst),
    .req    (req2),
    .gnt    (gnt2),
    .gnt_id (gnt_id2),
    .busy   (busy2),
    .abort  (abort2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard side: every gnt/abort pulse must match the head of its queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (gnt != 4'b0000) begin
        check("gnt_onehot", 32'($onehot(gnt)), 32'd1);
        if (gq.size() == 0) begin
          check("gnt_unexpected", 32'(gnt), 32'd0);
        end else begin
          e = gq.pop_front();
          check("gnt_vec", 32'(gnt), 32'd1 << e.id);
          check("gnt_cycle", cyc, e.cyc);
          check("gnt_id", 32'(gnt_id), e.id);
        end
        for (int i = 0; i < 4; i++) if (gnt[i]) req[i] = 1'b0;
      end
      if (abort) begin
        if (aq.size() == 0) check("abort_unexpected", 32'(abort), 32'd0);
        else check("abort_cycle", cyc, aq.pop_front());
      end
    end
  end

  initial begin
    int k;

    rst  = 1'b0;
    req  = 4'b1111;
    req2 = 2'b11;
    tick(3);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_abort", 32'(abort), 32'd0);
    check("rst_gnt_id", 32'(gnt_id), 32'd0);
    check("rst_lim_gnt", 32'(gnt2), 32'd0);
    req  = 4'b0000;
    req2 = 2'b00;
    rst  = 1'b1;
    tick(2);

    // Minimum service time on the 2-requester instance, including pointer wrap.
    req2 = 2'b11;
    for (int j = 0; j < 6; j++) begin
      tick(1);
      check("lim_gnt", 32'(gnt2), 32'(lim_gnt[j]));
      check("lim_busy", 32'(busy2), 32'(lim_busy[j]));
      check("lim_abort", 32'(abort2), 32'd0);
      if (j == 0) check("lim_id0", 32'(gnt_id2), 32'd0);
      if (j == 3) check("lim_id1", 32'(gnt_id2), 32'd1);
      for (int i = 0; i < 2; i++) if (gnt2[i]) req2[i] = 1'b0;
    end

    // Single request on requester 2.
    k = cyc;
    req[2] = 1'b1;
    gq.push_back('{2, k + 4});
    for (int j = 1; j <= 5; j++) begin
      tick(1);
      check("single_busy", 32'(busy), 32'(j <= 4));
      if (j == 1) check("single_id", 32'(gnt_id), 32'd2);
    end
    tick(1);

    // Pointer sits at 3: requester 3 first, then wrap to 0.
    k = cyc;
    req = req | 4'b1001;
    gq.push_back('{3, k + 4});
    gq.push_back('{0, k + 9});
    tick(10);

    // Requester 1 withdraws in its second SERVE cycle; pending requester 2 follows.
    k = cyc;
    req = req | 4'b0110;
    tick(1);
    check("wd_busy_sel", 32'(busy), 32'd1);
    check("wd_id_sel", 32'(gnt_id), 32'd1);
    tick(1);
    req[1] = 1'b0;
    aq.push_back(k + 3);
    gq.push_back('{2, k + 7});
    tick(1);
    check("wd_busy_abort", 32'(busy), 32'd0);
    check("wd_gnt_abort", 32'(gnt), 32'd0);
    tick(1);
    check("wd_busy_next", 32'(busy), 32'd1);
    check("wd_id_next", 32'(gnt_id), 32'd2);
    check("wd_abort_once", 32'(abort), 32'd0);
    tick(4);

    // Reset during SERVE drops the pending grant; held req[3] restarts with full latency.
    req[3] = 1'b1;
    tick(2);
    rst = 1'b0;
    #1;
    check("mrst_gnt", 32'(gnt), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_abort", 32'(abort), 32'd0);
    check("mrst_gnt_id", 32'(gnt_id), 32'd0);
    tick(2);
    rst = 1'b1;
    k = cyc;
    gq.push_back('{3, k + 4});
    tick(1);
    check("mrst_busy_sel", 32'(busy), 32'd1);
    check("mrst_id_sel", 32'(gnt_id), 32'd3);
    tick(4);

    // All four requesting: order 0,1,2,3; re-raised req[0] waits behind the rest.
    k = cyc;
    req = 4'b1111;
    gq.push_back('{0, k + 4});
    gq.push_back('{1, k + 9});
    gq.push_back('{2, k + 14});
    gq.push_back('{3, k + 19});
    gq.push_back('{0, k + 24});
    tick(5);
    req[0] = 1'b1;

    for (int t = 0; t < 60 && (gq.size() != 0 || aq.size() != 0); t++) tick(1);
    check("drain", gq.size() + aq.size(), 32'd0);
    tick(2);
    check("final_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/req_gnt_responder.md
Name: req_gnt_responder

Overview:
- Multi-requester responder for the single-bit req/gnt handshake.
- Each requester raises req, holds it until it sees a one-cycle gnt, then drops it. A requester may also withdraw req early.
- The block arbitrates N_REQ requesters round-robin and models a fixed service time before granting.
- Sits between several request masters and one shared resource; it replaces the single-requester edge-detect slave.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- ID_W, 2, width of grant index; must equal clog2(N_REQ)
- SVC_CYCLES, 3, service cycles between selection and gnt (1..15)
- CNT_W, 4, width of service down-counter; must hold SVC_CYCLES-1

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- req  input  N_REQ  level request per requester; held until gnt or withdrawn
- gnt  output  N_REQ  registered one-hot grant pulse, one cycle wide
- gnt_id  output  ID_W  index of requester currently selected/granted; valid while busy=1
- busy  output  1  high from selection until grant completes or aborts
- abort  output  1  one-cycle pulse when the selected requester withdraws during service

Behaviour:
- Reset (rst=0, async) forces the following, all registered:
  - state=IDLE, gnt=0, gnt_id=0, busy=0, abort=0
  - rr pointer ptr=0, counter cnt=0
- States: IDLE, SERVE, GRANT (2-bit encoding).
- IDLE:
  - If any req is high, pick the winner: first high req scanning ptr, ptr+1, ... modulo N_REQ.
  - At the edge: sel/gnt_id<=winner, busy<=1, cnt<=SVC_CYCLES-1, state<=SERVE.
  - If no req is high, stay in IDLE.
- SERVE:
  - If req[sel]=0 (withdrawn): abort<=1 for one cycle, busy<=0, ptr<=sel+1 mod N_REQ, state<=IDLE. No gnt is issued.
  - Else if cnt==0: gnt[sel]<=1, state<=GRANT.
  - Else cnt<=cnt-1.
- GRANT:
  - gnt[sel] is high for exactly this cycle.
  - At the edge: gnt<=0, busy<=0, ptr<=sel+1 mod N_REQ, state<=IDLE.
  - The requester drops req on the same edge, so the next IDLE cycle never re-selects the stale req.
- Latency: req[i] is first sampled high in IDLE in cycle k, and i wins. Then:
  - busy is high in cycles k+1..k+SVC_CYCLES+1.
  - gnt[i] is high in cycle k+SVC_CYCLES+1 (k+4 at default).
- Back-to-back: a new selection may occur in the IDLE cycle directly after GRANT. Throughput is one grant per SVC_CYCLES+2 cycles.
- Requests from non-selected requesters arriving or withdrawn during SERVE/GRANT are ignored until the next IDLE.
- gnt is always one-hot or zero; never more than one bit set.
- Pointer wrap: sel=N_REQ-1 sets ptr<=0.
- Reset asserted mid-service: immediate return to reset values; any pending gnt is lost.
- Must not be instantiated with SVC_CYCLES=0; there is no reset-time check, so a bench must cover the parameter limits.

Decomposition:
- Package req_gnt_pkg holds:
  - state encoding constants IDLE=2'd0, SERVE=2'd1, GRANT=2'd2
  - default parameter constants
- One combinational sub-module, rr_pick:
  - inputs: req vector and ptr
  - outputs: winner index and a valid flag
  - implemented as a rotate/priority-scan so it can be unit-tested alone.
- FSM, counter and output registers live in req_gnt_responder.

Test Plan:
- Reset: hold rst=0 with req=4'b1111 -> gnt=0, busy=0, abort=0, gnt_id=0. Release rst.
- Single request: req[2]=1 from cycle 10, dropped the cycle after gnt -> busy=1 in cycles 11..14; gnt=4'b0100 only in cycle 14; busy=0 in cycle 15.
- Round-robin fairness: req=4'b1111 held, each requester dropping its bit after its gnt -> grant order 0,1,2,3. The next grant to requester 0 comes only after all others. Grants are spaced 5 cycles apart.
- Wrap-around: ptr at 3, req=4'b1001 -> requester 3 granted first, then requester 0.
- Withdrawal: req[1] dropped in the 2nd SERVE cycle -> abort pulses 1 cycle, gnt stays 0, busy falls. The next pending req[2] is selected in the following IDLE cycle.
- Mid-service reset: pulse rst=0 during SERVE -> all outputs 0 immediately. After release, a held req[3] is granted with full latency again, and ptr starts from 0.
